rf_op_sequencer: RTL and testbench

Micro-op sequencer for the 8x16 register file: accepts one register-to-register ALU instruction via a valid/ready handshake and drives the file's read/write ports.
- Reads two source registers, computes a 16-bit ALU result with flags, and writes the result back to a destination register.
- Sits between the instruction source (testbench or fetch logic) and the register file, and is the sole driver of the file's address, write-enable and write-data inputs.

---
 rtl/rf_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rf_op_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_op_sequencer.sv
// Register-file micro-op sequencer: IDLE -> READ -> EXEC -> WRITE, 4 cycles per instruction.
// Accepts a new instruction only in IDLE (instr_ready); fields presented in other states are ignored.
module rf_op_sequencer #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_rs1,
   input  logic [AW-1:0] instr_rs2,
   input  logic [DW-1:0] instr_imm,
   output logic [AW-1:0] rf_rd_addr_a,
   output logic [AW-1:0] rf_rd_addr_b,
   input  logic [DW-1:0] rf_d_out_a,
   input  logic [DW-1:0] rf_d_out_b,
   output logic          rf_wr,
   output logic [AW-1:0] rf_wr_addr,
   output logic [DW-1:0] rf_d_in,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          zero,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_LDI = 3'b110;
   localparam logic [2:0] OP_MOV = 3'b111;

   state_t        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] rs1_q, rs1_d;
   logic [AW-1:0] rs2_q, rs2_d;
   logic [DW-1:0] imm_q, imm_d;
   logic [DW-1:0] opa_q, opa_d;
   logic [DW-1:0] opb_q, opb_d;
   logic [DW-1:0] result_q, result_d;
   logic          carry_q, carry_d;
   logic          zero_q, zero_d;

   logic [DW:0]   alu_ext;
   logic [DW-1:0] alu_res;
   logic          alu_c;

   // 17-bit extended arithmetic: bit DW is the ADD carry or the SUB borrow.
   always_comb begin
      alu_ext = '0;
      case (op_q)
         OP_ADD:  alu_ext = {1'b0, opa_q} + {1'b0, opb_q};
         OP_SUB:  alu_ext = {1'b0, opa_q} - {1'b0, opb_q};
         OP_AND:  alu_ext = {1'b0, opa_q & opb_q};
         OP_OR:   alu_ext = {1'b0, opa_q | opb_q};
         OP_XOR:  alu_ext = {1'b0, opa_q ^ opb_q};
         OP_NOT:  alu_ext = {1'b0, ~opa_q};
         OP_LDI:  alu_ext = {1'b0, imm_q};
         OP_MOV:  alu_ext = {1'b0, opa_q};
         default: alu_ext = '0;
      endcase
      alu_res = alu_ext[DW-1:0];
      alu_c   = alu_ext[DW];
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               op_d    = instr_op;
               rd_d    = instr_rd;
               rs1_d   = instr_rs1;
               rs2_d   = instr_rs2;
               imm_d   = instr_imm;
               state_d = READ;
            end
         end
         READ: begin
            opa_d   = rf_d_out_a;
            opb_d   = rf_d_out_b;
            state_d = EXEC;
         end
         EXEC: begin
            result_d = alu_res;
            carry_d  = alu_c;
            zero_d   = (alu_res == '0);
            state_d  = WRITE;
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   // Strobes come straight from the state register so they cannot glitch.
   assign instr_ready  = (state_q == IDLE);
   assign rf_wr        = (state_q == WRITE);
   assign done         = (state_q == WRITE);
   assign rf_wr_addr   = rd_q;
   assign rf_d_in      = result_q;
   assign rf_rd_addr_a = rs1_q;
   assign rf_rd_addr_b = rs2_q;
   assign result       = result_q;
   assign carry        = carry_q;
   assign zero         = zero_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: behavioural register file plus an instruction-level reference model.
module tb_rf_op_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [2:0]  instr_op = '0;
   logic [2:0]  instr_rd = '0;
   logic [2:0]  instr_rs1 = '0;
   logic [2:0]  instr_rs2 = '0;
   logic [15:0] instr_imm = '0;
   logic [2:0]  rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
   logic [15:0] rf_d_out_a, rf_d_out_b, rf_d_in, result;
   logic        rf_wr, carry, zero, done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rf_op_sequencer #(.DW(16), .AW(3)) dut (
      .clk(clk), .reset(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
      .instr_rs2(instr_rs2), .instr_imm(instr_imm),
      .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
      .rf_d_out_a(rf_d_out_a), .rf_d_out_b(rf_d_out_b),
      .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
      .result(result), .carry(carry), .zero(zero), .done(done)
   );

   // Environment register file: 8x16, combinational reads, cleared by the shared reset.
   logic [15:0] rf [8];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (rf_wr) begin
         rf[rf_wr_addr] <= rf_d_in;
      end
   end
   assign rf_d_out_a = rf[rf_rd_addr_a];
   assign rf_d_out_b = rf[rf_rd_addr_b];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: returns {carry, result} for one instruction from its operand values.
   function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] imm);
      case (op)
         3'd0: ref_alu = 17'(a) + 17'(b);
         3'd1: ref_alu = {(a < b), 16'(a - b)};
         3'd2: ref_alu = {1'b0, a & b};
         3'd3: ref_alu = {1'b0, a | b};
         3'd4: ref_alu = {1'b0, a ^ b};
         3'd5: ref_alu = {1'b0, ~a};
         3'd6: ref_alu = {1'b0, imm};
         default: ref_alu = {1'b0, a};
      endcase
   endfunction

   // Model: cycles since accept (0 = free), architectural registers and the visible flags.
   int          m_age;
   logic [15:0] m_regs [8];
   logic [16:0] m_val;
   logic [2:0]  m_rd;
   logic [15:0] m_res;
   logic        m_c, m_z;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_age <= 0;
         m_val <= '0;
         m_rd  <= '0;
         m_res <= '0;
         m_c   <= 1'b0;
         m_z   <= 1'b0;
         for (int i = 0; i < 8; i++) m_regs[i] <= '0;
      end else if (m_age == 0) begin
         if (instr_valid) begin
            m_val <= ref_alu(instr_op, m_regs[instr_rs1], m_regs[instr_rs2], instr_imm);
            m_rd  <= instr_rd;
            m_age <= 1;
         end
      end else if (m_age == 2) begin
         m_res <= m_val[15:0];
         m_c   <= m_val[16];
         m_z   <= (m_val[15:0] == 16'h0);
         m_age <= 3;
      end else if (m_age == 3) begin
         m_regs[m_rd] <= m_val[15:0];
         m_age <= 0;
      end else begin
         m_age <= m_age + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("ready", instr_ready, (m_age == 0));
         chk("done", done, (m_age == 3));
         chk("rf_wr", rf_wr, (m_age == 3));
         chk("result", result, m_res);
         chk("carry", carry, m_c);
         chk("zero", zero, m_z);
         if (m_age == 3) begin
            chk("wr_addr", rf_wr_addr, m_rd);
            chk("wr_data", rf_d_in, m_val[15:0]);
         end
         for (int i = 0; i < 8; i++) chk("regfile", rf[i], m_regs[i]);
      end
   end

   // Present one instruction in IDLE, wait for its WRITE, and return in the next IDLE cycle.
   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [15:0] imm, input bit hold);
      int n;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!instr_ready) chk("ready_timeout", instr_ready, 1);
      instr_valid = 1'b1;
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
      @(posedge clk); #1;
      chk("ready_after_accept", instr_ready, 0);
      if (!hold) instr_valid = 1'b0;
      n = 0;
      while (!done && n < 10) begin
         if (hold) begin
            instr_op  = 3'($urandom);
            instr_rd  = 3'($urandom);
            instr_rs1 = 3'($urandom);
            instr_rs2 = 3'($urandom);
            instr_imm = 16'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      chk("done_latency", n, 2);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("done_width", done, 0);
   endtask

   initial begin
      #3;
      chk("rst_ready", instr_ready, 1);
      chk("rst_rf_wr", rf_wr, 0);
      chk("rst_done", done, 0);
      chk("rst_result", {carry, zero, result}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic load/add
      issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h1234, 0);
      issue(3'd6, 3'd2, 3'd0, 3'd0, 16'h00FF, 0);
      issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0, 0);
      chk("t1_r3", rf[3], 16'h1333);
      chk("t1_flags", {carry, zero}, 2'b00);

      // Wrap-around and borrow
      issue(3'd6, 3'd4, 3'd0, 3'd0, 16'hFFFF, 0);
      issue(3'd6, 3'd5, 3'd0, 3'd0, 16'h0001, 0);
      issue(3'd0, 3'd6, 3'd4, 3'd5, 16'h0, 0);
      chk("t2_r6", rf[6], 16'h0000);
      chk("t2_add_flags", {carry, zero}, 2'b11);
      issue(3'd1, 3'd7, 3'd6, 3'd5, 16'h0, 0);
      chk("t2_r7", rf[7], 16'hFFFF);
      chk("t2_sub_flags", {carry, zero}, 2'b10);

      // Logic ops
      issue(3'd6, 3'd1, 3'd0, 3'd0, 16'hF0F0, 0);
      issue(3'd6, 3'd2, 3'd0, 3'd0, 16'h0FF0, 0);
      issue(3'd2, 3'd3, 3'd1, 3'd2, 16'h0, 0);
      chk("t3_and", rf[3], 16'h00F0);
      issue(3'd3, 3'd4, 3'd1, 3'd2, 16'h0, 0);
      chk("t3_or", rf[4], 16'hFFF0);
      issue(3'd4, 3'd5, 3'd1, 3'd2, 16'h0, 0);
      chk("t3_xor", rf[5], 16'hFF00);
      chk("t3_xor_carry", carry, 0);
      issue(3'd5, 3'd6, 3'd1, 3'd0, 16'h0, 0);
      chk("t3_not", rf[6], 16'h0F0F);
      issue(3'd7, 3'd0, 3'd1, 3'd0, 16'h0, 0);
      chk("t3_mov", rf[0], 16'hF0F0);
      chk("t3_mov_carry", carry, 0);

      // Destination equal to source, back to back
      issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h4000, 0);
      issue(3'd0, 3'd1, 3'd1, 3'd1, 16'h0, 0);
      chk("t4_r1", rf[1], 16'h8000);
      issue(3'd0, 3'd2, 3'd1, 3'd1, 16'h0, 0);
      chk("t4_r2", rf[2], 16'h0000);
      chk("t4_flags", {carry, zero}, 2'b11);

      // Valid held with changing fields while busy
      issue(3'd6, 3'd3, 3'd0, 3'd0, 16'hBEEF, 1);
      chk("t5_r3", rf[3], 16'hBEEF);

      // Random traffic
      for (int k = 0; k < 80; k++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
               16'($urandom), bit'($urandom_range(0, 1)));
      end

      // Reset during EXEC
      issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h1111, 0);
      issue(3'd6, 3'd2, 3'd0, 3'd0, 16'h2222, 0);
      issue(3'd6, 3'd3, 3'd0, 3'd0, 16'h5555, 0);
      instr_valid = 1'b1;
      instr_op = 3'd0; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("t6_ready", instr_ready, 1);
      chk("t6_rf_wr", rf_wr, 0);
      chk("t6_done", done, 0);
      chk("t6_flags", {carry, zero, result}, 0);
      @(posedge clk); #1;
      chk("t6_rf_wr_held", rf_wr, 0);
      rst = 1'b0;
      chk("t6_r3_cleared", rf[3], 16'h0000);
      issue(3'd7, 3'd0, 3'd3, 3'd0, 16'h0, 0);
      chk("t6_read_r3", result, 16'h0000);
      chk("t6_zero", zero, 1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
